// File: rtl/tx_scheduler.sv
// tx_scheduler: shares the laser transmitter (serial_tx) between a control
// packet source (SYN/ACK/FIN from the main state machine) and a data packet
// source (packet generator). After every frame it forces an idle gap, and it
// runs the go-back-n retransmission timer for data frames.
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   ctrl_valid/ctrl_packet       control request and its packet
//   ctrl_grant                   one-cycle pulse, control packet accepted
//   data_valid/data_packet       data request and its packet
//   data_grant                   one-cycle pulse, data packet accepted
//   tx_data, tx_new_data         packet and start pulse towards serial_tx
//   tx_done                      end-of-frame pulse from serial_tx
//   ack_rcvd                     in-window ACK pulse, stops the timer
//   retransmit                   one-cycle pulse, timer expired
//   sent_data                    one-cycle pulse when a data frame finishes
//   timer_active                 retransmission timer running
//   sched_busy                   scheduler not in IDLE
//   state_dbg                    current FSM state (IDLE=0, SEND=1, GAP=2)
//
// Handshake: a source raises *_valid with its packet stable and keeps both
// until it sees the one-cycle *_grant pulse; the packet is captured on the
// edge that produces the grant. Dropping valid before the grant withdraws
// the request; valid still high after the grant is a fresh request.
module tx_scheduler #(
  parameter int PKT_LENGTH      = 288,
  parameter int GAP_CYCLES      = 54166,
  parameter int TIMEOUT         = 130000000,
  parameter int MAX_CTRL_STREAK = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ctrl_valid,
  input  logic [PKT_LENGTH-1:0] ctrl_packet,
  output logic                  ctrl_grant,
  input  logic                  data_valid,
  input  logic [PKT_LENGTH-1:0] data_packet,
  output logic                  data_grant,
  output logic [PKT_LENGTH-1:0] tx_data,
  output logic                  tx_new_data,
  input  logic                  tx_done,
  input  logic                  ack_rcvd,
  output logic                  retransmit,
  output logic                  sent_data,
  output logic                  timer_active,
  output logic                  sched_busy,
  output logic [1:0]            state_dbg
);

  localparam int GAP_W    = ($clog2(GAP_CYCLES + 1) > 17) ? $clog2(GAP_CYCLES + 1) : 17;
  localparam int STREAK_W = (MAX_CTRL_STREAK > 0) ? $clog2(MAX_CTRL_STREAK + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CTRL_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [31:0]         timer_cnt;
  logic [STREAK_W-1:0] streak;
  logic                frame_is_data;
  logic                data_wins;

  // Control normally wins; data is forced once control has taken
  // MAX_CTRL_STREAK grants in a row while data was waiting.
  assign data_wins  = data_valid && (!ctrl_valid || (streak == STREAK_MAX));
  assign sched_busy = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      timer_cnt     <= '0;
      streak        <= '0;
      frame_is_data <= 1'b0;
      tx_data       <= '0;
      tx_new_data   <= 1'b0;
      ctrl_grant    <= 1'b0;
      data_grant    <= 1'b0;
      sent_data     <= 1'b0;
      retransmit    <= 1'b0;
      timer_active  <= 1'b0;
    end else begin
      ctrl_grant  <= 1'b0;
      data_grant  <= 1'b0;
      tx_new_data <= 1'b0;
      sent_data   <= 1'b0;
      retransmit  <= 1'b0;

      // Retransmission timer. An ACK on the expiry cycle suppresses the
      // retransmit. A data tx_done below reloads it and overrides this.
      if (timer_active) begin
        if (ack_rcvd) begin
          timer_active <= 1'b0;
          timer_cnt    <= '0;
        end else if (timer_cnt == 32'd1) begin
          timer_active <= 1'b0;
          timer_cnt    <= '0;
          retransmit   <= 1'b1;
        end else begin
          timer_cnt <= timer_cnt - 32'd1;
        end
      end

      case (state)
        IDLE: begin
          if (data_wins) begin
            data_grant    <= 1'b1;
            tx_new_data   <= 1'b1;
            tx_data       <= data_packet;
            frame_is_data <= 1'b1;
            streak        <= '0;
            state         <= SEND;
          end else if (ctrl_valid) begin
            ctrl_grant    <= 1'b1;
            tx_new_data   <= 1'b1;
            tx_data       <= ctrl_packet;
            frame_is_data <= 1'b0;
            // Only a grant that made data wait extends the streak.
            if (!data_valid)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + STREAK_W'(1);
            state         <= SEND;
          end
        end

        SEND: begin
          if (tx_done) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES);
            if (frame_is_data) begin
              sent_data    <= 1'b1;
              timer_cnt    <= 32'(TIMEOUT);
              timer_active <= 1'b1;
            end
          end
        end

        GAP: begin
          // GAP_CYCLES decrements plus the cycle that sees zero.
          if (gap_cnt == '0)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - GAP_W'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with GAP_CYCLES=4, TIMEOUT=20,
// MAX_CTRL_STREAK=2. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so every observed value is the one
// registered on the edge just passed.
module tb_tx_scheduler;

  localparam int PKT_LENGTH = 288;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                  ctrl_valid = 1'b0;
  logic [PKT_LENGTH-1:0] ctrl_packet = '0;
  logic                  ctrl_grant;
  logic                  data_valid = 1'b0;
  logic [PKT_LENGTH-1:0] data_packet = '0;
  logic                  data_grant;
  logic [PKT_LENGTH-1:0] tx_data;
  logic                  tx_new_data;
  logic                  tx_done = 1'b0;
  logic                  ack_rcvd = 1'b0;
  logic                  retransmit;
  logic                  sent_data;
  logic                  timer_active;
  logic                  sched_busy;
  logic [1:0]            state_dbg;

  tx_scheduler #(
    .PKT_LENGTH(PKT_LENGTH),
    .GAP_CYCLES(4),
    .TIMEOUT(20),
    .MAX_CTRL_STREAK(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctrl_valid(ctrl_valid),
    .ctrl_packet(ctrl_packet),
    .ctrl_grant(ctrl_grant),
    .data_valid(data_valid),
    .data_packet(data_packet),
    .data_grant(data_grant),
    .tx_data(tx_data),
    .tx_new_data(tx_new_data),
    .tx_done(tx_done),
    .ack_rcvd(ack_rcvd),
    .retransmit(retransmit),
    .sent_data(sent_data),
    .timer_active(timer_active),
    .sched_busy(sched_busy),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input logic [PKT_LENGTH-1:0] obs,
                           input logic [PKT_LENGTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until any grant appears; bounded by budget.
  task automatic wait_grant(input int budget, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (ctrl_grant || data_grant) ok = 1'b1;
    end
  endtask

  // Hard stop in case something wedges the sequence below.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [PKT_LENGTH-1:0] pkt_a5;
    logic [PKT_LENGTH-1:0] pkt_c3;
    logic [PKT_LENGTH-1:0] pkt_5a;
    logic [5:0]            order_is_data;
    int                    n;
    logic                  ok;

    pkt_a5        = {36{8'hA5}};
    pkt_c3        = {36{8'hC3}};
    pkt_5a        = {36{8'h5A}};
    order_is_data = 6'b100100;  // k=0..5: ctrl ctrl data ctrl ctrl data

    // Reset state
    tick(); tick();
    check_pkt("rst_tx_data", tx_data, '0);
    check_bit("rst_tx_new_data", tx_new_data, 1'b0);
    check_bit("rst_grants", ctrl_grant | data_grant, 1'b0);
    check_bit("rst_pulses", retransmit | sent_data, 1'b0);
    check_bit("rst_timer_active", timer_active, 1'b0);
    check_bit("rst_sched_busy", sched_busy, 1'b0);
    check_st("rst_state", state_dbg, 2'd0);
    reset_n = 1'b1;
    tick();

    // Single data request, then timeout with no ACK
    data_packet = pkt_a5;
    data_valid  = 1'b1;
    tick();
    check_bit("d1_grant", data_grant, 1'b1);
    check_bit("d1_ctrl_grant", ctrl_grant, 1'b0);
    check_bit("d1_new_data", tx_new_data, 1'b1);
    check_pkt("d1_tx_data", tx_data, pkt_a5);
    check_st("d1_state_send", state_dbg, 2'd1);
    data_valid = 1'b0;
    tick();
    check_bit("d1_grant_pulse_end", data_grant | tx_new_data, 1'b0);
    tick(); tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_bit("d1_sent_data", sent_data, 1'b1);
    check_bit("d1_timer_on", timer_active, 1'b1);
    check_st("d1_state_gap", state_dbg, 2'd2);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) check_bit("d1_sent_data_end", sent_data, 1'b0);
      if (i == 4) check_bit("d1_busy_in_gap", sched_busy, 1'b1);
      if (i == 5) check_st("d1_idle_after_gap", state_dbg, 2'd0);
      check_bit("d1_retransmit", retransmit, (i == 20));
      check_bit("d1_timer_active", timer_active, (i != 20));
    end
    tick();
    check_bit("d1_retransmit_end", retransmit, 1'b0);

    // ACK five cycles after tx_done stops the timer
    data_valid = 1'b1;
    tick();
    check_bit("d2_grant", data_grant, 1'b1);
    data_valid = 1'b0;
    tick(); tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_bit("d2_timer_on", timer_active, 1'b1);
    tick(); tick(); tick(); tick();
    ack_rcvd = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    check_bit("d2_ack_stops_timer", timer_active, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit("d2_no_retransmit", retransmit, 1'b0);
    end

    // Priority: both sources held high -> ctrl ctrl data ctrl ctrl data
    ctrl_packet = pkt_c3;
    data_packet = pkt_5a;
    ctrl_valid  = 1'b1;
    data_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_grant(20, n, ok);
      check_bit("pr_grant_seen", ok, 1'b1);
      check_int("pr_grant_latency", n, (k == 0) ? 1 : 6);
      check_bit("pr_data_grant", data_grant, order_is_data[k]);
      check_bit("pr_ctrl_grant", ctrl_grant, !order_is_data[k]);
      check_pkt("pr_tx_data", tx_data, order_is_data[k] ? pkt_5a : pkt_c3);
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check_bit("pr_sent_data", sent_data, order_is_data[k]);
    end
    ctrl_valid = 1'b0;
    data_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check_bit("pr_timer_done", timer_active, 1'b0);
    check_st("pr_idle", state_dbg, 2'd0);

    // Control frame inside a running timer leaves the count alone
    data_packet = pkt_a5;
    data_valid  = 1'b1;
    tick();
    check_bit("cf_data_grant", data_grant, 1'b1);
    data_valid = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_bit("cf_sent_data", sent_data, 1'b1);
    ctrl_valid = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      check_bit("cf_ctrl_grant", ctrl_grant, (i == 6));
      check_bit("cf_retransmit", retransmit, (i == 20));
      if (i == 6) ctrl_valid = 1'b0;
      if (i == 7) tx_done = 1'b1;
      if (i == 8) begin
        tx_done = 1'b0;
        check_bit("cf_no_sent_data", sent_data, 1'b0);
        check_st("cf_gap", state_dbg, 2'd2);
      end
      if (i == 19) check_bit("cf_timer_still_on", timer_active, 1'b1);
      if (i == 20) check_bit("cf_timer_off", timer_active, 1'b0);
    end

    // ACK on the expiry cycle suppresses retransmit
    data_valid = 1'b1;
    tick();
    check_bit("ae_data_grant", data_grant, 1'b1);
    data_valid = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      check_bit("ae_no_retransmit", retransmit, 1'b0);
      if (i == 19) begin
        check_bit("ae_timer_on", timer_active, 1'b1);
        ack_rcvd = 1'b1;
      end
      if (i == 20) begin
        ack_rcvd = 1'b0;
        check_bit("ae_timer_off", timer_active, 1'b0);
      end
    end

    // Spurious tx_done in IDLE
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_st("sp_state", state_dbg, 2'd0);
    check_bit("sp_busy", sched_busy, 1'b0);
    check_bit("sp_sent_data", sent_data, 1'b0);
    check_bit("sp_timer", timer_active, 1'b0);
    tick();
    check_st("sp_state_after", state_dbg, 2'd0);

    // Reset in SEND with the timer running
    data_valid = 1'b1;
    tick();
    check_bit("rm_first_grant", data_grant, 1'b1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_grant(10, n, ok);
    check_bit("rm_second_grant", data_grant, 1'b1);
    check_int("rm_second_latency", n, 6);
    check_bit("rm_timer_on", timer_active, 1'b1);
    data_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("rm_new_data_cleared", tx_new_data, 1'b0);
    check_bit("rm_grant_cleared", data_grant, 1'b0);
    check_bit("rm_busy_cleared", sched_busy, 1'b0);
    check_bit("rm_timer_cleared", timer_active, 1'b0);
    check_pkt("rm_tx_data_cleared", tx_data, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_bit("rm_quiet", ctrl_grant | data_grant | retransmit | tx_new_data, 1'b0);
    end
    check_bit("rm_idle_busy", sched_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Sequences the laser transmitter and shares it between two packet sources.
  - Control source: SYN/ACK/FIN-only packets from the main state machine.
  - Data source: data packets from the packet generator.
- Sits between those producers and serial_tx, and inserts a fixed idle gap between frames.
- Runs the go-back-n retransmission timer and reports timeouts back to the main state machine.

Parameters:
- PKT_LENGTH, 288, packet width in bits (9 × 32-bit words).
- GAP_CYCLES, 54166, idle clock cycles forced after each tx_done (one bit time at 1200 baud, 65 MHz).
- TIMEOUT, 130000000, retransmission timeout in clock cycles (2 s at 65 MHz); must be ≥ 1.
- MAX_CTRL_STREAK, 3, consecutive control grants allowed while data is waiting before data is forced.

Ports:
- clk  in  1  system clock (65 MHz)
- reset_n  in  1  asynchronous, active-low reset
- ctrl_valid  in  1  control packet pending; held high until ctrl_grant
- ctrl_packet  in  PKT_LENGTH  control packet; stable while ctrl_valid is high
- ctrl_grant  out  1  one-cycle pulse: control packet accepted
- data_valid  in  1  data packet pending; held high until data_grant
- data_packet  in  PKT_LENGTH  data packet; stable while data_valid is high
- data_grant  out  1  one-cycle pulse: data packet accepted
- tx_data  out  PKT_LENGTH  packet to serial_tx
- tx_new_data  out  1  one-cycle start pulse to serial_tx
- tx_done  in  1  one-cycle pulse from serial_tx at end of frame
- ack_rcvd  in  1  one-cycle pulse: valid in-window ACK received; stops the timer
- retransmit  out  1  one-cycle pulse: timer expired
- sent_data  out  1  one-cycle pulse on tx_done of a data packet
- timer_active  out  1  retransmission timer running
- sched_busy  out  1  state ≠ IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; tx_data = 0.
  - All pulse outputs = 0; timer_active = 0.
  - Streak, gap and timer counters = 0.
  - Reset mid-frame abandons the frame. No grant or retransmit is issued for it.
- States and transitions:
  - IDLE: if any valid is sampled high at edge E, a winner is chosen. In the cycle after E:
    - the winner's grant = 1 and tx_new_data = 1;
    - tx_data = the winner's packet, registered at E;
    - state = SEND.
  - SEND: waits for tx_done, then moves to GAP and loads the gap counter with GAP_CYCLES. Valid inputs are ignored.
  - GAP: counts down. When it reaches 0 the state returns to IDLE, so the next grant comes no earlier than GAP_CYCLES+1 cycles after tx_done. With GAP_CYCLES = 0, GAP lasts one cycle.
- Arbitration (evaluated in IDLE only):
  - Control has priority, except when data_valid = 1 and streak = MAX_CTRL_STREAK; then data wins.
  - Streak counter:
    - +1 on each ctrl grant made while data_valid = 1;
    - cleared on any data grant;
    - cleared on a ctrl grant made while data_valid = 0;
    - saturates at MAX_CTRL_STREAK.
  - Only one source is granted per frame.
- Frame tracking: the granted source type is latched in SEND.
  - tx_done ending a data frame: sent_data pulses and the retransmission timer (re)loads to TIMEOUT, timer_active = 1.
  - tx_done ending a control frame leaves the timer untouched.
  - tx_done outside SEND is ignored.
- Timer: while active, decrements by 1 per cycle.
  - At the cycle the count reaches 0: retransmit = 1 for one cycle and timer_active = 0.
  - ack_rcvd while active: stops the timer (timer_active = 0 next cycle) with no retransmit.
  - ack_rcvd and expiry in the same cycle: ack wins, no retransmit.
  - ack_rcvd and data tx_done in the same cycle: the reload wins.
  - The timer keeps running across control frames and gaps.
- A valid input dropped before its grant is legal; the request is withdrawn.
- Valid held high after its grant is treated as a new request at the next IDLE.
- Counter widths: gap counter ≥ 17 bits; timer ≥ 28 bits (use 32); streak counter holds MAX_CTRL_STREAK.

Test Plan (bench parameters: GAP_CYCLES = 4, TIMEOUT = 20, MAX_CTRL_STREAK = 2, PKT_LENGTH = 288):
- Single data request, data_packet = 288'hA5…: data_valid at edge 0.
  - Cycle 1: data_grant = 1, tx_new_data = 1, tx_data = A5….
  - tx_done at cycle 10 → sent_data at cycle 10 and timer_active = 1.
  - Next grant possible no earlier than cycle 15.
- Timeout: after the above, no ack → retransmit pulses exactly 20 cycles after tx_done, then timer_active = 0. With ack_rcvd 5 cycles after tx_done → no retransmit.
- Priority: ctrl_valid and data_valid both high continuously → grant order ctrl, ctrl, data, ctrl, ctrl, data…, separated by gaps.
- Reset mid-frame: reset_n low during SEND → tx_new_data = 0, sched_busy = 0, timer_active = 0 immediately. After release with no valids: no grant and no retransmit for 50 cycles.
- Simultaneous events: ack_rcvd on the expiry cycle → retransmit stays 0. Control tx_done while the timer runs → timer keeps its count.
- Spurious tx_done in IDLE → no state change, no sent_data.
